mitm_rule_engine: RTL and testbench

Parametrised successor to the single-constant SPI/Microwire MITM decision block. It sits between the line samplers and the MISO/MOSI write buffers. It decodes each EEPROM transaction segment by segment and looks up the target address in a runtime-programmable rule table. On a hit it substitutes rule data on MISO for reads, and, when configured, on MOSI for writes. Segment framing uses the existing `eval`/`eval_done` and `mitm_start`/`mitm_done` handshakes.

---
 rtl/mitm_rule_engine_pkg.sv | 33 +++
 rtl/mitm_rule_table.sv | 62 ++++++
 rtl/mitm_rule_engine.sv | 198 +++++++++++++++++++
 tb/tb_mitm_rule_engine.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mitm_rule_engine_pkg.sv
// Shared state encodings, opcodes and sizing helpers for the MITM rule engine.
package mitm_pkg;

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_INSTR  = 3'd2;
    localparam logic [2:0] ST_OPCODE = 3'd3;
    localparam logic [2:0] ST_ADDR   = 3'd4;
    localparam logic [2:0] ST_LOOKUP = 3'd5;
    localparam logic [2:0] ST_DATA   = 3'd6;
    // Unused code: reset parks here so the first clock after release lands in RESET.
    localparam logic [2:0] ST_POR    = 3'd7;

    localparam logic [2:0] OP_READ  = 3'b110;
    localparam logic [2:0] OP_WRITE = 3'b101;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int calc_max_data_size(input int addr_bits, input int word_bits);
        return max_int(max_int(addr_bits + 1, word_bits), 3);
    endfunction

    function automatic int calc_data_size_width(input int max_data_size);
        return $clog2(max_data_size + 1);
    endfunction

    function automatic int calc_idx_w(input int num_rules);
        return max_int(1, $clog2(num_rules));
    endfunction

endpackage

// File: rtl/mitm_rule_table.sv
// Runtime-programmable rule table: registered valid/addr/data entries with a
// combinational lowest-index-wins address match.
module mitm_rule_table
    import mitm_pkg::*;
#(
    parameter int ADDR_BITS = 6,
    parameter int WORD_BITS = 8,
    parameter int NUM_RULES = 4,
    localparam int IDX_W = calc_idx_w(NUM_RULES)
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 i_cfg_we,
    input  logic [IDX_W-1:0]     i_cfg_idx,
    input  logic                 i_cfg_valid,
    input  logic [ADDR_BITS-1:0] i_cfg_addr,
    input  logic [WORD_BITS-1:0] i_cfg_data,
    input  logic [ADDR_BITS-1:0] i_lookup_addr,
    output logic                 o_hit,
    output logic [IDX_W-1:0]     o_hit_idx,
    output logic [WORD_BITS-1:0] o_hit_data
);

    logic [NUM_RULES-1:0] r_valid;
    logic [ADDR_BITS-1:0] r_addr [NUM_RULES];
    logic [WORD_BITS-1:0] r_data [NUM_RULES];
    logic                 w_write;

    assign w_write = i_cfg_we && (int'(i_cfg_idx) < NUM_RULES);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (w_write) begin
            r_valid[i_cfg_idx] <= i_cfg_valid;
        end
    end

    // NOTE: payload storage is not reset; the valid bits alone gate every match.
    always_ff @(posedge sys_clk) begin
        if (w_write) begin
            r_addr[i_cfg_idx] <= i_cfg_addr;
            r_data[i_cfg_idx] <= i_cfg_data;
        end
    end

    // NOTE: defaults assigned first so no output holds a stale value and no latch is inferred.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_idx  = '0;
        o_hit_data = '0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_addr[i] == i_lookup_addr)) begin
                o_hit      = 1'b1;
                o_hit_idx  = IDX_W'(i);
                o_hit_data = r_data[i];
            end
        end
    end

endmodule

// File: rtl/mitm_rule_engine.sv
// SPI/Microwire MITM decision engine with a programmable substitution rule table.
// Define MITM_WRITE_PROTECT_EN to also substitute MOSI data on WRITE transactions.
module mitm_rule_engine
    import mitm_pkg::*;
#(
    parameter int ADDR_BITS = 6,
    parameter int WORD_BITS = 8,
    parameter int NUM_RULES = 4,
    localparam int MAX_DATA_SIZE   = calc_max_data_size(ADDR_BITS, WORD_BITS),
    localparam int DATA_SIZE_WIDTH = calc_data_size_width(MAX_DATA_SIZE),
    localparam int IDX_W           = calc_idx_w(NUM_RULES)
) (
    input  logic                       sys_clk,
    input  logic                       rst_n,
    input  logic                       mitm_start,
    input  logic                       eval,
    input  logic [MAX_DATA_SIZE-1:0]   real_miso_data,
    input  logic [MAX_DATA_SIZE-1:0]   real_mosi_data,
    input  logic                       cfg_we,
    input  logic [IDX_W-1:0]           cfg_idx,
    input  logic                       cfg_valid,
    input  logic [ADDR_BITS-1:0]       cfg_addr,
    input  logic [WORD_BITS-1:0]       cfg_data,
    output logic [MAX_DATA_SIZE-1:0]   fake_miso_data,
    output logic [MAX_DATA_SIZE-1:0]   fake_mosi_data,
    output logic [DATA_SIZE_WIDTH-1:0] data_size,
    output logic                       fake_miso_select,
    output logic                       fake_mosi_select,
    output logic                       eval_done,
    output logic                       mitm_done,
    output logic [15:0]                hit_count
);

`ifdef MITM_WRITE_PROTECT_EN
    localparam logic WRITE_PROTECT = 1'b1;
`else
    localparam logic WRITE_PROTECT = 1'b0;
`endif

    logic [2:0]                 r_state;
    logic                       r_is_write;
    logic [ADDR_BITS-1:0]       r_addr;
    logic [MAX_DATA_SIZE-1:0]   r_fake_miso;
    logic [MAX_DATA_SIZE-1:0]   r_fake_mosi;
    logic [DATA_SIZE_WIDTH-1:0] r_data_size;
    logic                       r_miso_sel;
    logic                       r_mosi_sel;
    logic                       r_eval_done;
    logic                       r_mitm_done;
    logic [15:0]                r_hit_count;

    logic                       w_eval_ok;
    logic [2:0]                 w_opcode;
    logic [ADDR_BITS-1:0]       w_addr_capture;
    logic                       w_hit;
    logic [IDX_W-1:0]           w_hit_idx;
    logic [WORD_BITS-1:0]       w_hit_data;
    logic [MAX_DATA_SIZE-1:0]   w_fake_word;
    logic                       w_unused;

    assign w_eval_ok      = eval && r_eval_done;
    assign w_opcode       = real_mosi_data[2:0];
    // READ addresses are followed by a dummy bit, so they sit one position higher.
    assign w_addr_capture = r_is_write ? real_mosi_data[ADDR_BITS-1:0]
                                       : real_mosi_data[ADDR_BITS:1];
    assign w_unused       = ^{real_miso_data, real_mosi_data, w_hit_idx};

    always_comb begin
        w_fake_word = '0;
        w_fake_word[MAX_DATA_SIZE-1 -: WORD_BITS] = w_hit_data;
    end

    mitm_rule_table #(
        .ADDR_BITS (ADDR_BITS),
        .WORD_BITS (WORD_BITS),
        .NUM_RULES (NUM_RULES)
    ) u_rule_table (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .i_cfg_we      (cfg_we),
        .i_cfg_idx     (cfg_idx),
        .i_cfg_valid   (cfg_valid),
        .i_cfg_addr    (cfg_addr),
        .i_cfg_data    (cfg_data),
        .i_lookup_addr (r_addr),
        .o_hit         (w_hit),
        .o_hit_idx     (w_hit_idx),
        .o_hit_data    (w_hit_data)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_POR;
            r_is_write  <= 1'b0;
            r_addr      <= '0;
            r_fake_miso <= '0;
            r_fake_mosi <= '0;
            r_data_size <= '0;
            r_miso_sel  <= 1'b0;
            r_mosi_sel  <= 1'b0;
            r_eval_done <= 1'b0;
            r_mitm_done <= 1'b0;
            r_hit_count <= '0;
        end else begin
            case (r_state)
                ST_RESET: begin
                    r_fake_miso <= '0;
                    r_fake_mosi <= '0;
                    r_data_size <= '0;
                    r_miso_sel  <= 1'b0;
                    r_mosi_sel  <= 1'b0;
                    r_eval_done <= 1'b1;
                    r_mitm_done <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (mitm_start) begin
                        r_mitm_done <= 1'b0;
                        r_state     <= ST_INSTR;
                    end
                end
                ST_INSTR: begin
                    if (w_eval_ok) begin
                        r_data_size <= DATA_SIZE_WIDTH'(3);
                        r_miso_sel  <= 1'b0;
                        r_mosi_sel  <= 1'b0;
                        r_state     <= ST_OPCODE;
                    end
                end
                ST_OPCODE: begin
                    if (w_eval_ok) begin
                        if (w_opcode == OP_READ) begin
                            r_is_write  <= 1'b0;
                            r_data_size <= DATA_SIZE_WIDTH'(ADDR_BITS + 1);
                            r_state     <= ST_ADDR;
                        end else if (WRITE_PROTECT && (w_opcode == OP_WRITE)) begin
                            r_is_write  <= 1'b1;
                            r_data_size <= DATA_SIZE_WIDTH'(ADDR_BITS);
                            r_state     <= ST_ADDR;
                        end else begin
                            r_data_size <= '0;
                            r_mitm_done <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_eval_ok) begin
                        r_addr      <= w_addr_capture;
                        r_eval_done <= 1'b0;
                        r_state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    r_data_size <= DATA_SIZE_WIDTH'(WORD_BITS);
                    if (w_hit) begin
                        if (r_is_write) begin
                            r_fake_mosi <= w_fake_word;
                            r_mosi_sel  <= 1'b1;
                        end else begin
                            r_fake_miso <= w_fake_word;
                            r_miso_sel  <= 1'b1;
                        end
                        if (r_hit_count != 16'hFFFF) begin
                            r_hit_count <= r_hit_count + 16'd1;
                        end
                    end
                    r_eval_done <= 1'b1;
                    r_state     <= ST_DATA;
                end
                ST_DATA: begin
                    if (w_eval_ok) begin
                        r_data_size <= '0;
                        r_miso_sel  <= 1'b0;
                        r_mosi_sel  <= 1'b0;
                        r_mitm_done <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_eval_done <= 1'b0;
                    r_mitm_done <= 1'b0;
                    r_state     <= ST_RESET;
                end
            endcase
        end
    end

    assign fake_miso_data   = r_fake_miso;
    assign fake_mosi_data   = r_fake_mosi;
    assign data_size        = r_data_size;
    assign fake_miso_select = r_miso_sel;
    assign fake_mosi_select = r_mosi_sel;
    assign eval_done        = r_eval_done;
    assign mitm_done        = r_mitm_done;
    assign hit_count        = r_hit_count;

endmodule

// File: tb/tb_mitm_rule_engine.sv
// Self-checking bench for mitm_rule_engine: transaction-level reference model,
// per-cycle output compare, directed scenarios plus randomized transactions.
module tb_mitm_rule_engine;

    localparam int A    = 6;
    localparam int W    = 8;
    localparam int N    = 4;
    localparam int MDS  = ((A + 1) > W) ? (((A + 1) > 3) ? (A + 1) : 3) : ((W > 3) ? W : 3);
    localparam int DSW  = $clog2(MDS + 1);
    localparam int IDXW = ($clog2(N) > 1) ? $clog2(N) : 1;
    localparam logic [2:0] OP_RD = 3'b110;
    localparam logic [2:0] OP_WR = 3'b101;
`ifdef MITM_WRITE_PROTECT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic            sys_clk = 1'b0;
    logic            rst_n;
    logic            mitm_start;
    logic            eval;
    logic [MDS-1:0]  real_miso_data;
    logic [MDS-1:0]  real_mosi_data;
    logic            cfg_we;
    logic [IDXW-1:0] cfg_idx;
    logic            cfg_valid;
    logic [A-1:0]    cfg_addr;
    logic [W-1:0]    cfg_data;
    logic [MDS-1:0]  fake_miso_data;
    logic [MDS-1:0]  fake_mosi_data;
    logic [DSW-1:0]  data_size;
    logic            fake_miso_select;
    logic            fake_mosi_select;
    logic            eval_done;
    logic            mitm_done;
    logic [15:0]     hit_count;

    mitm_rule_engine #(.ADDR_BITS(A), .WORD_BITS(W), .NUM_RULES(N)) dut (
        .sys_clk          (sys_clk),
        .rst_n            (rst_n),
        .mitm_start       (mitm_start),
        .eval             (eval),
        .real_miso_data   (real_miso_data),
        .real_mosi_data   (real_mosi_data),
        .cfg_we           (cfg_we),
        .cfg_idx          (cfg_idx),
        .cfg_valid        (cfg_valid),
        .cfg_addr         (cfg_addr),
        .cfg_data         (cfg_data),
        .fake_miso_data   (fake_miso_data),
        .fake_mosi_data   (fake_mosi_data),
        .data_size        (data_size),
        .fake_miso_select (fake_miso_select),
        .fake_mosi_select (fake_mosi_select),
        .eval_done        (eval_done),
        .mitm_done        (mitm_done),
        .hit_count        (hit_count)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: rule table contents and the expected output values.
    bit             m_valid [N];
    logic [A-1:0]   m_addr  [N];
    logic [W-1:0]   m_data  [N];
    int             exp_size;
    bit             exp_miso_sel, exp_mosi_sel, exp_eval_done, exp_mitm_done;
    int             exp_hits;
    logic [MDS-1:0] exp_fake_miso, exp_fake_mosi;
    bit             cmp_en = 1'b0;
    int             q_sizes [$];

    bit             pend_we;
    int             pend_idx;
    bit             pend_valid;
    logic [A-1:0]   pend_addr;
    logic [W-1:0]   pend_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_lookup(input logic [A-1:0] a, output logic [W-1:0] d);
        d = '0;
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && (m_addr[i] == a)) begin
                d = m_data[i];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [MDS-1:0] msb_align(input logic [W-1:0] d);
        logic [MDS-1:0] v;
        v = MDS'(d);
        return v << (MDS - W);
    endfunction

    function automatic logic [A-1:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return A'(6'h05);
            1:       return A'(6'h10);
            2:       return A'(6'h3F);
            default: return A'($urandom);
        endcase
    endfunction

    always @(negedge sys_clk) begin
        if (cmp_en) begin
            check("data_size", 32'(data_size), 32'(exp_size));
            check("fake_miso_select", 32'(fake_miso_select), 32'(exp_miso_sel));
            check("fake_mosi_select", 32'(fake_mosi_select), 32'(exp_mosi_sel));
            check("eval_done", 32'(eval_done), 32'(exp_eval_done));
            check("mitm_done", 32'(mitm_done), 32'(exp_mitm_done));
            check("hit_count", 32'(hit_count), 32'(exp_hits));
            if (exp_miso_sel) check("fake_miso_data", 32'(fake_miso_data), 32'(exp_fake_miso));
            if (exp_mosi_sel) check("fake_mosi_data", 32'(fake_mosi_data), 32'(exp_fake_mosi));
        end
    end

    task automatic tick(input bit rnd);
        if (rnd && ($urandom_range(0, 3) == 0)) begin
            cfg_we    = 1'b1;
            cfg_idx   = IDXW'($urandom_range(0, N - 1));
            cfg_valid = ($urandom_range(0, 3) != 0);
            cfg_addr  = pick_addr();
            cfg_data  = W'($urandom);
        end
        @(posedge sys_clk);
        #1;
        if (cfg_we) begin
            pend_we    = 1'b1;
            pend_idx   = int'(cfg_idx);
            pend_valid = cfg_valid;
            pend_addr  = cfg_addr;
            pend_data  = cfg_data;
        end
        cfg_we         = 1'b0;
        real_mosi_data = MDS'($urandom);
        real_miso_data = MDS'($urandom);
    endtask

    task automatic apply_pending();
        if (pend_we) begin
            m_valid[pend_idx] = pend_valid;
            m_addr[pend_idx]  = pend_addr;
            m_data[pend_idx]  = pend_data;
            pend_we = 1'b0;
        end
    endtask

    task automatic step(input bit rnd);
        tick(rnd);
        apply_pending();
    endtask

    task automatic cfg_write(input int idx, input bit valid, input logic [A-1:0] addr,
                             input logic [W-1:0] data);
        cfg_we = 1'b1; cfg_idx = IDXW'(idx); cfg_valid = valid; cfg_addr = addr; cfg_data = data;
        step(1'b0);
    endtask

    // Idle cycles inside a transaction; stray mitm_start here must be ignored.
    task automatic gap(input bit rnd);
        int n;
        n = rnd ? $urandom_range(0, 2) : 0;
        repeat (n) begin
            mitm_start = ($urandom_range(0, 7) == 0);
            step(rnd);
            mitm_start = 1'b0;
        end
    endtask

    task automatic seg_eval(input bit rnd);
        eval = 1'b1;
        step(rnd);
        eval = 1'b0;
    endtask

    task automatic txn_head(input logic [2:0] op, input logic [A-1:0] addr, input bit lookup_eval,
                            input bit rnd, output bit in_data);
        logic [MDS-1:0] v;
        logic [W-1:0]   d;
        bit             hit;
        bit             is_wr;
        in_data = 1'b0;
        is_wr   = WP && (op == OP_WR);
        if (rnd && ($urandom_range(0, 3) == 0)) seg_eval(rnd);
        mitm_start = 1'b1;
        step(rnd);
        mitm_start    = 1'b0;
        exp_mitm_done = 1'b0;
        gap(rnd);
        seg_eval(rnd);
        exp_size = 3; exp_miso_sel = 1'b0; exp_mosi_sel = 1'b0;
        q_sizes.push_back(int'(data_size));
        gap(rnd);
        v = MDS'($urandom);
        v[2:0] = op;
        real_mosi_data = v;
        seg_eval(rnd);
        if (op == OP_RD) begin
            exp_size = A + 1;
        end else if (is_wr) begin
            exp_size = A;
        end else begin
            exp_size = 0;
            exp_mitm_done = 1'b1;
            q_sizes.push_back(int'(data_size));
            return;
        end
        q_sizes.push_back(int'(data_size));
        gap(rnd);
        v = MDS'($urandom);
        if (is_wr) v[A-1:0] = addr;
        else       v[A:1]   = addr;
        real_mosi_data = v;
        seg_eval(rnd);
        exp_eval_done = 1'b0;
        eval = lookup_eval;
        tick(rnd);
        eval = 1'b0;
        hit = model_lookup(addr, d);
        apply_pending();
        exp_size = W;
        exp_eval_done = 1'b1;
        if (hit) begin
            if (is_wr) begin
                exp_mosi_sel = 1'b1; exp_fake_mosi = msb_align(d);
            end else begin
                exp_miso_sel = 1'b1; exp_fake_miso = msb_align(d);
            end
            if (exp_hits < 65535) exp_hits++;
        end
        q_sizes.push_back(int'(data_size));
        in_data = 1'b1;
    endtask

    task automatic txn_tail(input bit rnd);
        gap(rnd);
        seg_eval(rnd);
        exp_size = 0; exp_miso_sel = 1'b0; exp_mosi_sel = 1'b0; exp_mitm_done = 1'b1;
        q_sizes.push_back(int'(data_size));
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        #1;
        check("rst data_size", 32'(data_size), 32'h0);
        check("rst selects", 32'({fake_miso_select, fake_mosi_select}), 32'h0);
        check("rst done flags", 32'({eval_done, mitm_done}), 32'h0);
        check("rst fake data", 32'({fake_miso_data, fake_mosi_data}), 32'h0);
        check("rst hit_count", 32'(hit_count), 32'h0);
        exp_size = 0; exp_miso_sel = 1'b0; exp_mosi_sel = 1'b0;
        exp_eval_done = 1'b0; exp_mitm_done = 1'b0; exp_hits = 0;
        exp_fake_miso = '0; exp_fake_mosi = '0;
        pend_we = 1'b0;
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    endtask

    task automatic release_reset();
        step(1'b0);
        step(1'b0);
        rst_n = 1'b1;
        step(1'b0);
        check("done flags after 1st edge", 32'({eval_done, mitm_done}), 32'h0);
        step(1'b0);
        exp_eval_done = 1'b1;
        exp_mitm_done = 1'b1;
        check("done flags after 2nd edge", 32'({eval_done, mitm_done}), 32'h3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit       in_data;
        logic [2:0] op;
        rst_n = 1'b1; mitm_start = 1'b0; eval = 1'b0; cfg_we = 1'b0;
        cfg_idx = '0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
        real_miso_data = '0; real_mosi_data = '0; pend_we = 1'b0;
        @(posedge sys_clk);
        #1;
        assert_reset();
        cmp_en = 1'b1;
        release_reset();

        // Plain READ with an empty table: sizes 3, 7, 8, 0 and no substitution.
        q_sizes.delete();
        txn_head(OP_RD, A'(6'h05), 1'b0, 1'b0, in_data);
        check("T1 DATA selects", 32'({fake_miso_select, fake_mosi_select}), 32'h0);
        txn_tail(1'b0);
        check("T1 size seq0", 32'(q_sizes[0]), 32'd3);
        check("T1 size seq1", 32'(q_sizes[1]), 32'd7);
        check("T1 size seq2", 32'(q_sizes[2]), 32'd8);
        check("T1 size seq3", 32'(q_sizes[3]), 32'd0);
        check("T1 mitm_done", 32'(mitm_done), 32'h1);
        check("T1 hit_count", 32'(hit_count), 32'h0);

        // Reset during DATA aborts at once.
        txn_head(OP_RD, A'(6'h05), 1'b0, 1'b0, in_data);
        check("T0 in DATA", 32'(data_size), 32'd8);
        assert_reset();
        release_reset();

        // Single rule hit on READ.
        cfg_write(2, 1'b1, A'(6'h05), W'(8'h24));
        txn_head(OP_RD, A'(6'h05), 1'b0, 1'b0, in_data);
        check("T2 miso select", 32'(fake_miso_select), 32'h1);
        check("T2 miso data", 32'(fake_miso_data), 32'h24);
        check("T2 hit_count", 32'(hit_count), 32'd1);
        txn_tail(1'b0);

        // Priority between two rules on the same address.
        cfg_write(1, 1'b1, A'(6'h10), W'(8'hAA));
        cfg_write(3, 1'b1, A'(6'h10), W'(8'h55));
        txn_head(OP_RD, A'(6'h10), 1'b0, 1'b0, in_data);
        check("T3 low index wins", 32'(fake_miso_data), 32'hAA);
        txn_tail(1'b0);
        cfg_write(1, 1'b0, A'(6'h10), W'(8'hAA));
        txn_head(OP_RD, A'(6'h10), 1'b0, 1'b0, in_data);
        check("T3 after disable", 32'(fake_miso_data), 32'h55);
        check("T3 hit_count", 32'(hit_count), 32'd3);
        txn_tail(1'b0);

        // WRITE to a ruled address.
        txn_head(OP_WR, A'(6'h05), 1'b0, 1'b0, in_data);
`ifdef MITM_WRITE_PROTECT_EN
        check("T4 mosi select", 32'(fake_mosi_select), 32'h1);
        check("T4 mosi data", 32'(fake_mosi_data), 32'h24);
        check("T4 miso select", 32'(fake_miso_select), 32'h0);
        txn_tail(1'b0);
`else
        check("T4 size after opcode", 32'(data_size), 32'h0);
        check("T4 mitm_done", 32'(mitm_done), 32'h1);
        check("T4 mosi select", 32'(fake_mosi_select), 32'h0);
`endif

        // eval pulse during LOOKUP is dropped; engine still waits in DATA.
        txn_head(OP_RD, A'(6'h05), 1'b1, 1'b0, in_data);
        check("T5 still DATA size", 32'(data_size), 32'd8);
        check("T5 still busy", 32'({eval_done, mitm_done}), 32'h2);
        txn_tail(1'b0);

        // Randomized transactions with concurrent rule updates.
        repeat (250) begin
            case ($urandom_range(0, 4))
                0, 1, 2: op = OP_RD;
                3:       op = OP_WR;
                default: op = 3'($urandom);
            endcase
            txn_head(op, pick_addr(), ($urandom_range(0, 5) == 0), 1'b1, in_data);
            if (in_data) txn_tail(1'b1);
            repeat ($urandom_range(0, 2)) step(1'b1);
        end

        step(1'b0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
